pp_pipeline_accel_mat2axistream_pack: RTL and testbench

//  Transmit-side packer for the pre-processing pipeline: drains a frame of 8-bit

---
 rtl/pp_pipeline_accel_pkg.sv | 24 ++
 rtl/pp_pipeline_accel_mat2axistream_pack_if.sv | 35 +++
 rtl/pp_pipeline_accel_byte_packer.sv | 52 +++++
 rtl/pp_pipeline_accel_mat2axistream_pack.sv | 116 +++++++++++
 tb/tb_pp_pipeline_accel_mat2axistream_pack.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/pp_pipeline_accel_pkg.sv
// Shared constants and types for the pre-processing pipeline transmit packer.
//   PIX_W  : pixel width (one pixel per clock)
//   WORD_W : packed output word width
//   PPW    : pixels per packed word
//   IDX_W  : width of the byte index within a word
//   DIM_W  : significant bits of the rows/cols dimension words
package pp_pipeline_accel_pkg;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WORD_W = 64;
  localparam int unsigned PPW    = WORD_W / PIX_W;
  localparam int unsigned IDX_W  = $clog2(PPW);
  localparam int unsigned DIM_W  = 16;
  localparam int unsigned CNT_W  = 2 * DIM_W;

  typedef enum logic [2:0] {
    StIdle,
    StDim,
    StPack,
    StFlush,
    StDone
  } state_e;

endpackage

// File: rtl/pp_pipeline_accel_mat2axistream_pack_if.sv
// FIFO-side bus of the mat2axistream packer.
//   rows_*  : frame height FIFO (read side)
//   cols_*  : frame width FIFO (read side)
//   img_*   : pixel FIFO (read side)
//   ldata_* : packed word FIFO (write side)
// master = packer side, slave = FIFO / environment side.
interface pp_pipeline_accel_mat2axistream_pack_if;
  import pp_pipeline_accel_pkg::*;

  logic [31:0]       rows_dout;
  logic              rows_empty_n;
  logic              rows_read;
  logic [31:0]       cols_dout;
  logic              cols_empty_n;
  logic              cols_read;
  logic [PIX_W-1:0]  img_dout;
  logic              img_empty_n;
  logic              img_read;
  logic [WORD_W-1:0] ldata_din;
  logic              ldata_full_n;
  logic              ldata_write;

  modport master (
    input  rows_dout, rows_empty_n, cols_dout, cols_empty_n, img_dout, img_empty_n,
    input  ldata_full_n,
    output rows_read, cols_read, img_read, ldata_din, ldata_write
  );

  modport slave (
    output rows_dout, rows_empty_n, cols_dout, cols_empty_n, img_dout, img_empty_n,
    output ldata_full_n,
    input  rows_read, cols_read, img_read, ldata_din, ldata_write
  );

endinterface

// File: rtl/pp_pipeline_accel_byte_packer.sv
// Byte packer: accumulates pixels little-endian into a word-wide shift register.
//   ap_clk, ap_rst : clock, asynchronous active-high reset
//   clear          : restart at byte 0 with an empty register
//   push           : store pix at the current byte index, then advance the index
//   pix            : incoming pixel
//   idx            : current byte index (next byte to be written)
//   full_word      : {pix, stored low bytes}, valid as the completed word when idx is last
//   pad_word       : stored bytes below idx, bytes at and above idx forced to zero
module pp_pipeline_accel_byte_packer
  import pp_pipeline_accel_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              clear,
  input  logic              push,
  input  logic [PIX_W-1:0]  pix,
  output logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] full_word,
  output logic [WORD_W-1:0] pad_word
);

  logic [WORD_W-1:0] shreg_q;
  logic [IDX_W-1:0]  idx_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (clear) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (push) begin
      for (int k = 0; k < int'(PPW); k++) begin
        if (idx_q == IDX_W'(k)) shreg_q[k*PIX_W +: PIX_W] <= pix;
      end
      idx_q <= idx_q + IDX_W'(1); // wraps to 0 after the last byte
    end
  end

  assign idx       = idx_q;
  // The top byte comes straight from the input so the word leaves with the 8th pixel.
  assign full_word = {pix, shreg_q[WORD_W-PIX_W-1:0]};

  // Bytes at and above idx are stale from the previous word; zero them.
  always_comb begin
    pad_word = '0;
    for (int k = 0; k < int'(PPW); k++) begin
      if (IDX_W'(k) < idx_q) pad_word[k*PIX_W +: PIX_W] = shreg_q[k*PIX_W +: PIX_W];
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_mat2axistream_pack.sv
// Transmit-side packer: drains rows*cols pixels from the image FIFO and packs them
// contiguously (across rows) into 64-bit little-endian words; a partial last word
// is zero-padded. ap_ctrl_chain control.
//   ap_clk, ap_rst          : clock, asynchronous active-high reset
//   ap_start                : start a frame
//   ap_done                 : frame complete, held until ap_continue
//   ap_ready                : one-cycle pulse on entry to the done state
//   ap_idle                 : high only while idle
//   ap_continue             : downstream has consumed ap_done
//   bus (master)            : rows/cols/img read FIFOs and ldata write FIFO
module pp_pipeline_accel_mat2axistream_pack
  import pp_pipeline_accel_pkg::*;
(
  input  logic ap_clk,
  input  logic ap_rst,
  input  logic ap_start,
  output logic ap_done,
  output logic ap_ready,
  output logic ap_idle,
  input  logic ap_continue,
  pp_pipeline_accel_mat2axistream_pack_if.master bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  total_q, count_q;
  logic              ready_q;
  logic [CNT_W-1:0]  dim_total;
  logic              last_pix;
  logic              dims_ok;
  logic              word_end;

  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] full_word;
  logic [WORD_W-1:0] pad_word;

  pp_pipeline_accel_byte_packer u_packer (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .clear     (state_q == StDim),
    .push      (bus.img_read),
    .pix       (bus.img_dout),
    .idx       (idx),
    .full_word (full_word),
    .pad_word  (pad_word)
  );

  assign dim_total = {{DIM_W{1'b0}}, bus.rows_dout[DIM_W-1:0]} *
                     {{DIM_W{1'b0}}, bus.cols_dout[DIM_W-1:0]};
  assign dims_ok   = bus.rows_empty_n & bus.cols_empty_n;
  // total_q is non-zero whenever we are packing.
  assign last_pix  = (count_q == total_q - CNT_W'(1));
  assign word_end  = (idx == IDX_W'(PPW - 1));

  always_comb begin
    state_d         = state_q;
    ap_done         = 1'b0;
    ap_ready        = 1'b0;
    ap_idle         = 1'b0;
    bus.rows_read   = 1'b0;
    bus.cols_read   = 1'b0;
    bus.img_read    = 1'b0;
    bus.ldata_write = 1'b0;
    bus.ldata_din   = '0;

    unique case (state_q)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) state_d = StDim;
      end
      StDim: begin
        if (dims_ok) begin
          bus.rows_read = 1'b1;
          bus.cols_read = 1'b1;
          state_d       = (dim_total == '0) ? StDone : StPack;
        end
      end
      StPack: begin
        bus.ldata_din = full_word;
        // Never consume the 8th pixel unless its word can be written this cycle.
        bus.img_read    = bus.img_empty_n & (~word_end | bus.ldata_full_n);
        bus.ldata_write = bus.img_read & word_end;
        if (bus.img_read && last_pix) state_d = word_end ? StDone : StFlush;
      end
      StFlush: begin
        bus.ldata_din   = pad_word;
        bus.ldata_write = bus.ldata_full_n;
        if (bus.ldata_full_n) state_d = StDone;
      end
      StDone: begin
        ap_done  = 1'b1;
        ap_ready = ready_q;
        if (ap_continue) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= StIdle;
      total_q <= '0;
      count_q <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == StDone) && (state_q != StDone);
      if (state_q == StDim) begin
        count_q <= '0;
        if (dims_ok) total_q <= dim_total;
      end else if (bus.img_read) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_mat2axistream_pack.sv
module tb_pp_pipeline_accel_mat2axistream_pack;
  import pp_pipeline_accel_pkg::*;

  logic ap_clk = 1'b0;
  logic ap_rst, ap_start, ap_continue;
  logic ap_done, ap_ready, ap_idle;

  pp_pipeline_accel_mat2axistream_pack_if bus ();

  pp_pipeline_accel_mat2axistream_pack dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_continue (ap_continue),
    .bus         (bus)
  );

  always #5 ap_clk = ~ap_clk;

  // FIFO contents seen by the DUT and words it wrote
  logic [15:0] rowsq[$];
  logic [15:0] colsq[$];
  logic [7:0]  pixq[$];
  logic [63:0] got[$];

  int n_vec = 0, n_bad = 0;
  bit start_r = 0, cont_r = 0;
  int img_gap = 0, full_gap = 0;
  int cyc = 0, frame_pix = 0, ready_cnt = 0, last_write_cyc = 0, done_cyc = 0;
  bit done_seen = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, observe 3 time units later (well before posedge).
  task automatic cycle();
    @(negedge ap_clk);
    ap_start         = start_r;
    ap_continue      = cont_r;
    bus.rows_empty_n = (rowsq.size() > 0) && ($urandom_range(99) >= img_gap);
    bus.rows_dout    = (rowsq.size() > 0) ? {16'hA5C3, rowsq[0]} : 32'hDEAD_BEEF;
    bus.cols_empty_n = (colsq.size() > 0) && ($urandom_range(99) >= img_gap);
    bus.cols_dout    = (colsq.size() > 0) ? {16'h5A3C, colsq[0]} : 32'hFEED_F00D;
    bus.img_empty_n  = (pixq.size() > 0) && ($urandom_range(99) >= img_gap);
    bus.img_dout     = (pixq.size() > 0) ? pixq[0] : 8'hEE;
    bus.ldata_full_n = ($urandom_range(99) >= full_gap);
    #3;
    if (ap_idle || ap_done)
      check("quiet_ctl", 64'({bus.rows_read, bus.cols_read, bus.img_read, bus.ldata_write}),
            64'd0);
    if (bus.rows_read || bus.cols_read) begin
      check("dim_pair", 64'({bus.rows_read, bus.cols_read, bus.rows_empty_n, bus.cols_empty_n}),
            64'hF);
      if (rowsq.size() > 0) void'(rowsq.pop_front());
      if (colsq.size() > 0) void'(colsq.pop_front());
    end
    if (bus.img_read) begin
      check("img_avail", 64'(bus.img_empty_n), 64'd1);
      if (frame_pix % 8 == 7)
        check("idx7_write", 64'({bus.ldata_full_n, bus.ldata_write}), 64'h3);
      if (pixq.size() > 0) void'(pixq.pop_front());
      frame_pix++;
    end
    if (bus.ldata_write) begin
      check("wr_full_n", 64'(bus.ldata_full_n), 64'd1);
      got.push_back(bus.ldata_din);
      last_write_cyc = cyc;
    end
    if (ap_ready) begin
      ready_cnt++;
      check("ready_in_done", 64'(ap_done), 64'd1);
    end
    if (ap_done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
    cyc++;
  endtask

  task automatic run_frame(input int rows, input int cols, input int igap, input int fgap,
                           input int cont_wait, input bit seq, input int base,
                           input bit chk_lat);
    logic [7:0]  pix[$];
    logic [63:0] exp_w[$];
    logic [63:0] word;
    int npix, nw, guard;
    npix = rows * cols;
    for (int i = 0; i < npix; i++) begin
      logic [7:0] p;
      p = seq ? 8'(base + i) : 8'($urandom);
      pix.push_back(p);
      pixq.push_back(p);
    end
    // Reference: contiguous little-endian packing, zero pad in the last word
    nw = (npix + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int k = 0; k < 8; k++)
        if (w * 8 + k < npix) word = word | (64'(pix[w*8+k]) << (8 * k));
      exp_w.push_back(word);
    end
    rowsq.push_back(16'(rows));
    colsq.push_back(16'(cols));
    img_gap = igap; full_gap = fgap;
    got.delete(); frame_pix = 0; ready_cnt = 0; done_seen = 0;
    check("idle_pre", 64'(ap_idle), 64'd1);
    start_r = 1; cycle(); start_r = 0;
    guard = 0;
    while (!done_seen && guard < 4000) begin cycle(); guard++; end
    if (!done_seen) begin
      check("done_timeout", 64'd0, 64'd1);
      return;
    end
    check("n_words", 64'(got.size()), 64'(nw));
    for (int w = 0; w < nw && w < got.size(); w++) check("word", got[w], exp_w[w]);
    check("n_pix_read", 64'(frame_pix), 64'(npix));
    check("pix_left", 64'(pixq.size()), 64'd0);
    check("dims_left", 64'(rowsq.size() + colsq.size()), 64'd0);
    if (chk_lat && npix > 0) check("done_latency", 64'(done_cyc), 64'(last_write_cyc + 1));
    for (int i = 0; i < cont_wait; i++) begin
      cycle();
      check("done_hold", 64'(ap_done), 64'd1);
    end
    cont_r = 1; cycle(); cont_r = 0;
    cycle();
    check("idle_post", 64'({ap_idle, ap_done}), 64'h2);
    check("ready_once", 64'(ready_cnt), 64'd1);
  endtask

  initial begin
    int guard;
    ap_rst = 1; ap_start = 0; ap_continue = 0;
    bus.rows_dout = '0; bus.rows_empty_n = 0; bus.cols_dout = '0; bus.cols_empty_n = 0;
    bus.img_dout = '0; bus.img_empty_n = 0; bus.ldata_full_n = 0;
    #12;
    check("rst_ctl", 64'({ap_idle, ap_done, ap_ready}), 64'h4);
    check("rst_bus", 64'({bus.rows_read, bus.cols_read, bus.img_read, bus.ldata_write}), 64'd0);
    check("rst_din", bus.ldata_din, 64'd0);
    @(negedge ap_clk); ap_rst = 0;

    run_frame(4, 4, 0, 0, 0, 1, 0, 1);   // two full words, done one cycle after last write
    run_frame(3, 3, 0, 0, 0, 1, 1, 0);   // FLUSH word 0x09
    run_frame(0, 640, 0, 0, 0, 0, 0, 0); // empty frame, no writes
    for (int i = 0; i < 3; i++) run_frame(1, 16, 40, 40, 0, 0, 0, 0);
    run_frame(3, 5, 20, 20, 5, 0, 0, 0); // ap_done held through 5 low ap_continue cycles
    run_frame(2, 4, 20, 20, 0, 0, 0, 0); // must pack from byte 0 again

    // Reset after 5 of 16 pixels
    rowsq.push_back(16'd1); colsq.push_back(16'd16);
    for (int i = 0; i < 16; i++) pixq.push_back(8'($urandom));
    img_gap = 0; full_gap = 0; got.delete(); frame_pix = 0;
    start_r = 1; cycle(); start_r = 0;
    guard = 0;
    while (frame_pix < 5 && guard < 100) begin cycle(); guard++; end
    check("rst_mid_reach", 64'(frame_pix), 64'd5);
    #1 ap_rst = 1;
    #1;
    check("rst_mid_ctl", 64'({ap_idle, ap_done, ap_ready}), 64'h4);
    check("rst_mid_bus", 64'({bus.rows_read, bus.cols_read, bus.img_read, bus.ldata_write}),
          64'd0);
    check("rst_mid_words", 64'(got.size()), 64'd0);
    @(negedge ap_clk); ap_rst = 0;
    pixq.delete(); rowsq.delete(); colsq.delete();
    run_frame(4, 4, 0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 6; i++)
      run_frame($urandom_range(6, 1), $urandom_range(9, 1), $urandom_range(50),
                $urandom_range(50), $urandom_range(3), 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
